// File: rtl/cache_line_xfer_pkg.sv
// Shared constants and encodings for the cache line transfer responder.
// Line and beat widths are fixed; beat size uses the memory-port size encoding.
package cache_line_xfer_pkg;

    localparam int BUS_64 = 64;
    localparam int LINE_W = 512;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the last beat: blks is clamped so the beats never run past the line.
    function automatic logic [5:0] beat_last(input logic [1:0] size, input logic [7:0] blks);
        logic [7:0] max_m1;
        max_m1 = (8'd64 >> size) - 8'd1;
        beat_last = (blks > max_m1) ? max_m1[5:0] : blks[5:0];
    endfunction

    function automatic logic [BUS_64-1:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  lane_mask = 64'h0000_0000_0000_00FF;
            SIZE_H:  lane_mask = 64'h0000_0000_0000_FFFF;
            SIZE_W:  lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/cache_line_xfer.sv
// Memory-side responder for cache line requests: splits a line read/write into
// single-beat req/ack transfers and assembles read beats back into a line.
//
// state   | meaning
// IDLE    | waiting for a line request; latches its fields on valid
// XFER    | issuing beat k, advancing on each ack until the last beat
// DONE    | one-cycle ready pulse with the assembled line
module cache_line_xfer
    import cache_line_xfer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cache_rw_axi_valid,
    input  logic                i_cache_rw_axi_op,
    input  logic [BUS_64-1:0]   i_cache_rw_axi_addr,
    input  logic [LINE_W-1:0]   i_cache_rw_axi_wdata,
    input  logic [1:0]          i_cache_rw_axi_size,
    input  logic [7:0]          i_cache_rw_axi_blks,
    output logic                o_cache_rw_axi_ready,
    output logic [LINE_W-1:0]   o_cache_rw_axi_rdata,
    output logic                o_mem_req,
    output logic                o_mem_op,
    output logic [BUS_64-1:0]   o_mem_addr,
    output logic [1:0]          o_mem_size,
    output logic [BUS_64-1:0]   o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic [BUS_64-1:0]   i_mem_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic                r_op;
    logic [BUS_64-1:0]   r_addr;
    logic [1:0]          r_size;
    logic [5:0]          r_last;
    logic [5:0]          r_k;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_buf;

    logic [8:0]          w_shift;
    logic [BUS_64-1:0]   w_mask;
    logic [LINE_W-1:0]   w_lane;

    // Bit offset of beat k inside the line: k * (8 << size).
    assign w_shift = {3'b000, r_k} << ({1'b0, r_size} + 3'd3);
    assign w_mask  = lane_mask(r_size);
    assign w_lane  = LINE_W'(i_mem_rdata & w_mask) << w_shift;

    assign o_mem_addr           = r_addr + (BUS_64'(r_k) << r_size);
    assign o_mem_wdata          = BUS_64'(r_wdata >> w_shift) & w_mask;
    assign o_mem_op             = r_op;
    assign o_mem_size           = r_size;
    assign o_cache_rw_axi_rdata = r_buf;

    always_comb begin
        w_next               = r_state;
        o_mem_req            = 1'b0;
        o_cache_rw_axi_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cache_rw_axi_valid) w_next = ST_XFER;
            end
            ST_XFER: begin
                o_mem_req = 1'b1;
                if (i_mem_ack && (r_k == r_last)) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_cache_rw_axi_ready = 1'b1;
                w_next               = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_last  <= '0;
            r_k     <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (i_cache_rw_axi_valid) begin
                        r_op    <= i_cache_rw_axi_op;
                        r_addr  <= i_cache_rw_axi_addr;
                        r_size  <= i_cache_rw_axi_size;
                        r_last  <= beat_last(i_cache_rw_axi_size, i_cache_rw_axi_blks);
                        r_wdata <= i_cache_rw_axi_wdata;
                        r_buf   <= '0;
                        r_k     <= '0;
                    end
                end
                ST_XFER: begin
                    if (i_mem_ack) begin
                        // Buffer is cleared on accept, so OR-ing each lane in is enough.
                        if (!r_op) r_buf <= r_buf | w_lane;
                        if (r_k != r_last) r_k <= r_k + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer: a scoreboard of expected beats is
// filled per request and drained as the DUT issues memory beats.
module tb_cache_line_xfer;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_cache_rw_axi_valid = 1'b0;
    logic           i_cache_rw_axi_op = 1'b0;
    logic [63:0]    i_cache_rw_axi_addr = '0;
    logic [511:0]   i_cache_rw_axi_wdata = '0;
    logic [1:0]     i_cache_rw_axi_size = '0;
    logic [7:0]     i_cache_rw_axi_blks = '0;
    logic           o_cache_rw_axi_ready;
    logic [511:0]   o_cache_rw_axi_rdata;
    logic           o_mem_req;
    logic           o_mem_op;
    logic [63:0]    o_mem_addr;
    logic [1:0]     o_mem_size;
    logic [63:0]    o_mem_wdata;
    logic           i_mem_ack = 1'b0;
    logic [63:0]    i_mem_rdata = '0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } beat_t;

    beat_t          sb_q[$];
    int             n_checks = 0;
    int             n_fail = 0;
    logic [511:0]   last_line;
    logic [63:0]    last_beat_addr;

    cache_line_xfer dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_cache_rw_axi_valid (i_cache_rw_axi_valid),
        .i_cache_rw_axi_op    (i_cache_rw_axi_op),
        .i_cache_rw_axi_addr  (i_cache_rw_axi_addr),
        .i_cache_rw_axi_wdata (i_cache_rw_axi_wdata),
        .i_cache_rw_axi_size  (i_cache_rw_axi_size),
        .i_cache_rw_axi_blks  (i_cache_rw_axi_blks),
        .o_cache_rw_axi_ready (o_cache_rw_axi_ready),
        .o_cache_rw_axi_rdata (o_cache_rw_axi_rdata),
        .o_mem_req            (o_mem_req),
        .o_mem_op             (o_mem_op),
        .o_mem_addr           (o_mem_addr),
        .o_mem_size           (o_mem_size),
        .o_mem_wdata          (o_mem_wdata),
        .i_mem_ack            (i_mem_ack),
        .i_mem_rdata          (i_mem_rdata)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One line request; rmode picks the memory return pattern (0: 0x1111..*(k+1), 1: 0xFFFFFFFF_0000000k, 2: random).
    task automatic run_xfer(input bit op, input logic [63:0] addr, input logic [1:0] size,
                            input logic [7:0] blks, input logic [511:0] wdata,
                            input int max_wait, input int rmode);
        int           w;
        int           n;
        int           cyc;
        int           waits;
        int           wcnt;
        int           extra;
        bit           done;
        bit           gap;
        logic [63:0]  mask;
        logic [511:0] exp_line;
        beat_t        b;

        w = 8 << size;
        n = ((int'(blks) + 1) < (512 / w)) ? int'(blks) + 1 : 512 / w;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        exp_line = '0;
        sb_q.delete();
        for (int k = 0; k < n; k++) begin
            b.addr  = addr + 64'(k) * (64'd1 << size);
            b.wdata = 64'(wdata >> (k * w)) & mask;
            case (rmode)
                0:       b.rdata = 64'h1111_1111_1111_1111 * 64'(k + 1);
                1:       b.rdata = 64'hFFFF_FFFF_0000_0000 | 64'(k);
                default: b.rdata = {$urandom, $urandom};
            endcase
            if (!op) exp_line = exp_line | (512'(b.rdata & mask) << (k * w));
            sb_q.push_back(b);
        end

        @(negedge clk);
        i_cache_rw_axi_valid = 1'b1;
        i_cache_rw_axi_op    = op;
        i_cache_rw_axi_addr  = addr;
        i_cache_rw_axi_size  = size;
        i_cache_rw_axi_blks  = blks;
        i_cache_rw_axi_wdata = wdata;

        cyc = 0; waits = 0; extra = 0; done = 0; gap = 0;
        wcnt = $urandom_range(0, max_wait);
        while (!done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            i_mem_ack = 1'b0;
            if (o_cache_rw_axi_ready) begin
                done = 1;
                last_line = o_cache_rw_axi_rdata;
                i_cache_rw_axi_valid = 1'b0;
            end else if (o_mem_req) begin
                if (wcnt > 0) begin
                    wcnt--;
                    waits++;
                end else begin
                    if (sb_q.size() == 0) begin
                        extra++;
                        i_mem_rdata = '0;
                    end else begin
                        b = sb_q.pop_front();
                        chk("beat_addr", 512'(o_mem_addr), 512'(b.addr));
                        chk("beat_op", 512'(o_mem_op), 512'(op));
                        chk("beat_size", 512'(o_mem_size), 512'(size));
                        if (op) chk("beat_wdata", 512'(o_mem_wdata), 512'(b.wdata));
                        i_mem_rdata = b.rdata;
                    end
                    last_beat_addr = o_mem_addr;
                    i_mem_ack = 1'b1;
                    wcnt = $urandom_range(0, max_wait);
                end
            end else begin
                gap = 1;
            end
        end
        i_cache_rw_axi_valid = 1'b0;
        chk("ready_seen", 512'(done), 512'(1));
        chk("latency", 512'(cyc), 512'(n + 1 + waits));
        chk("beats_left", 512'(sb_q.size()), 512'(0));
        chk("extra_beats", 512'(extra), 512'(0));
        chk("req_gap", 512'(gap), 512'(0));
        if (!op) chk("line", last_line, exp_line);
        @(posedge clk); #1;
        chk("ready_pulse_1cyc", 512'(o_cache_rw_axi_ready), 512'(0));
        chk("idle_req", 512'(o_mem_req), 512'(0));
        chk("rdata_hold", o_cache_rw_axi_rdata, last_line);
    endtask

    initial begin
        logic [511:0] wd;
        int           guard;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 512'(o_mem_req), 512'(0));
        chk("rst_ready", 512'(o_cache_rw_axi_ready), 512'(0));
        chk("rst_addr", 512'(o_mem_addr), 512'(0));
        chk("rst_wdata", 512'(o_mem_wdata), 512'(0));
        chk("rst_op", 512'(o_mem_op), 512'(0));
        chk("rst_size", 512'(o_mem_size), 512'(0));
        chk("rst_rdata", o_cache_rw_axi_rdata, 512'(0));
        rst = 1'b0;

        // Read 8x8B zero-wait
        run_xfer(1'b0, 64'h8000_0040, 2'd3, 8'd7, '0, 0, 0);
        chk("rd8_lo", 512'(last_line[63:0]), 512'(64'h1111_1111_1111_1111));
        chk("rd8_hi", 512'(last_line[511:448]), 512'(64'h8888_8888_8888_8888));
        chk("rd8_last_addr", 512'(last_beat_addr), 512'(64'h8000_0078));

        // Write 8x8B with random waits
        wd = '0;
        for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'hA5C3_0000_0000_0000 | (64'(k) * 64'h0101_0101_0101);
        run_xfer(1'b1, 64'h0000_0000_0001_0000, 2'd3, 8'd7, wd, 3, 2);
        run_xfer(1'b1, 64'h0000_0000_0002_0000, 2'd3, 8'd7, {16{$urandom}}, 3, 2);

        // Read 4x4B, upper rdata bits must be dropped
        run_xfer(1'b0, 64'h100, 2'd2, 8'd3, '0, 0, 1);
        chk("rd4_lo", 512'(last_line[127:0]), 512'({32'h3, 32'h2, 32'h1, 32'h0}));
        chk("rd4_hi", 512'(last_line[511:128]), 512'(0));

        // Clamp: blks 20 at 8B is 8 beats
        run_xfer(1'b0, 64'h4000, 2'd3, 8'd20, '0, 1, 2);
        // Byte beats: clamp at 64, and a small half-word write
        run_xfer(1'b0, 64'h7, 2'd0, 8'd255, '0, 0, 2);
        run_xfer(1'b1, 64'h202, 2'd1, 8'd5, {16{$urandom}}, 2, 2);

        // Address wrap
        run_xfer(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 8'd1, '0, 0, 2);
        chk("wrap_addr", 512'(last_beat_addr), 512'(64'h0));

        // Reset mid-burst at beat 3 of 8
        @(negedge clk);
        i_cache_rw_axi_valid = 1'b1;
        i_cache_rw_axi_op    = 1'b0;
        i_cache_rw_axi_addr  = 64'h2000;
        i_cache_rw_axi_size  = 2'd3;
        i_cache_rw_axi_blks  = 8'd7;
        guard = 0;
        i_mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        while (guard < 50) begin
            @(posedge clk); #1;
            guard++;
            i_cache_rw_axi_valid = 1'b0;
            i_mem_ack = 1'b0;
            if (o_mem_req && o_mem_addr == 64'h2018) break;
            i_mem_ack = o_mem_req;
        end
        chk("mid_beat3_reached", 512'(guard < 50), 512'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", 512'(o_mem_req), 512'(0));
        chk("midrst_ready", 512'(o_cache_rw_axi_ready), 512'(0));
        chk("midrst_addr", 512'(o_mem_addr), 512'(0));
        chk("midrst_rdata", o_cache_rw_axi_rdata, 512'(0));
        rst = 1'b0;
        i_mem_ack = 1'b1;
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        chk("late_ack_req", 512'(o_mem_req), 512'(0));
        chk("late_ack_ready", 512'(o_cache_rw_axi_ready), 512'(0));
        run_xfer(1'b0, 64'h3000, 2'd3, 8'd0, '0, 0, 0);
        chk("post_rst_line", last_line, 512'(64'h1111_1111_1111_1111));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
